servo_cmd_decoder: RTL and testbench
====================================

// Module: servo_cmd_decoder
// PURPOSE
//  Sits between uart_rx and the servo PWM channels. Parses the received byte stream into
//  framed, checksummed per-channel position commands and holds the latest good value per servo.
//  Frame = SYNC, ID, VALUE, CHK, where CHK = SYNC ^ ID ^ VALUE.
//  Replaces the unframed select/value byte pairs with a resynchronising, error-reporting parser.
// PARAMETERS
//  NUM_SERVOS     3       number of servo channels (1..8)
//  DEFAULT_VALUE  8'd127  value every channel holds after reset
//  TIMEOUT_CLKS   120000  idle clocks mid-frame before the partial frame is dropped (10 ms at 12 MHz)
// PORTS
//  clk          in   1             system clock
//  rst          in   1             reset, asynchronous, active-high
//  rx_dv        in   1             byte-valid from uart_rx
//  rx_byte      in   8             received byte, stable while rx_dv is high
//  servo_value  out  8*NUM_SERVOS  packed held values; channel n = [8n+7:8n]
//  servo_upd    out  NUM_SERVOS    one-cycle pulse, bit n = channel n updated this cycle
//  frame_active out  1             high while a frame is partially received
//  err_chk      out  1             one-cycle pulse, checksum mismatch
//  err_id       out  1             one-cycle pulse, good checksum but ID >= NUM_SERVOS
//  err_timeout  out  1             one-cycle pulse, mid-frame timeout
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset is asynchronous and active-high (rst).
//  - Reset values:
//    - servo_value: every channel = DEFAULT_VALUE.
//    - servo_upd, frame_active, err_* : 0.
//    - FSM: S_SYNC. Timeout counter: 0. Edge register: 0.
//  - Reset mid-frame discards the partial frame.
//  - Byte acceptance:
//    - A byte is taken only on the rising edge of rx_dv (rx_dv=1 and registered rx_dv=0).
//    - A strobe held high for several cycles counts as one byte.
//  - FSM states: S_SYNC, S_ID, S_VALUE, S_CHK. All transitions happen on byte acceptance only.
//    - S_SYNC: byte == SYNC_BYTE goes to S_ID. Any other byte is silently ignored.
//    - S_ID: latch id, go to S_VALUE. Any 8-bit ID is accepted here.
//    - S_VALUE: latch value, go to S_CHK. 0x00..0xFF are all legal, including SYNC_BYTE.
//    - S_CHK: always returns to S_SYNC, with one of three outcomes:
//      - checksum wrong: err_chk pulses; no commit; err_id does not pulse (checksum error has priority).
//      - checksum right and id >= NUM_SERVOS: err_id pulses; no commit.
//      - otherwise: servo_value[id] <= value and servo_upd[id] pulses.
//  - Latency: the commit and all pulses appear on the clock edge after the accepting cycle (1 clk).
//    All outputs are registered.
//  - Timeout:
//    - Counter clears on every accepted byte and whenever state == S_SYNC.
//    - It increments otherwise and saturates at TIMEOUT_CLKS-1.
//    - At that count: state goes to S_SYNC, err_timeout pulses, counter clears.
//    - Byte acceptance in the same cycle as the timeout: the byte wins and no timeout occurs.
//  - Width and arithmetic:
//    - Checksum is 8-bit XOR; no carries.
//    - Timeout counter width = $clog2(TIMEOUT_CLKS).
//    - ID comparison is unsigned over all 8 bits.
//  - frame_active = (state != S_SYNC), registered.
//  - Commit writes a single channel; other channels are untouched.
// STRUCTURE
//  - Shared package servo_cmd_pkg:
//    - SYNC_BYTE = 8'hA5
//    - state encoding localparams (2 bits)
//    - function frame_chk(id, value)
//  - Sub-module servo_frame_timer: timeout counter.
//    - Inputs: clk, rst, clear, run.
//    - Output: expired pulse.
//  - FSM, edge detect and value registers stay in this module.
// TESTING
//  1. Good frame: reset, then send A5 01 40 E4.
//     -> servo_value ch1 = 0x40; servo_upd = 3'b010 for one clk; ch0 and ch2 stay 0x7F; no err_*.
//  2. Resync through garbage: send 00 12 FF A5 02 33 94.
//     -> ch2 = 0x33 with a single servo_upd[2] pulse; no err_*.
//  3. Bad checksum: send A5 02 80 00.
//     -> err_chk pulse; ch2 unchanged; err_id stays 0; frame_active low afterwards.
//  4. Bad ID: send A5 05 10 B0.
//     -> err_id pulse; no servo_upd; all values unchanged.
//  5. Timeout: send A5 00, then idle TIMEOUT_CLKS clks.
//     -> err_timeout pulse exactly once; frame_active falls.
//     -> Then A5 00 C8 6D gives ch0 = 0xC8.
//  6. Reset and long strobe:
//     - Send A5 01, assert rst, then send 40 E4 -> ch1 stays 0x7F; no pulses.
//     - Hold rx_dv high for 3 clks on each byte of A5 00 11 B4 -> ch0 = 0x11 committed once.

Source files
------------

// File: rtl/servo_cmd_pkg.sv
// Shared constants, parser state encoding and frame checksum helper
// for the servo command decoder.
package servo_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_ID    = 2'd1;
  localparam logic [1:0] ST_VALUE = 2'd2;
  localparam logic [1:0] ST_CHK   = 2'd3;

  typedef enum logic [1:0] {
    S_SYNC  = ST_SYNC,
    S_ID    = ST_ID,
    S_VALUE = ST_VALUE,
    S_CHK   = ST_CHK
  } state_e;

  // Expected CHK byte: SYNC ^ ID ^ VALUE, plain 8-bit XOR.
  function automatic logic [7:0] frame_chk(
    input logic [7:0] id,
    input logic [7:0] value
  );
    return SYNC_BYTE ^ id ^ value;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Mid-frame idle timer. Ports: clk, rst (async high), clear, run,
// expired (one-cycle pulse when the idle count reaches its limit).
module servo_frame_timer #(
  parameter int TIMEOUT_CLKS = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW =
    (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_q;

  // A clear in the same cycle suppresses expiry, so an
  // accepted byte always beats the timeout.
  assign expired = run && !clear && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || !run || expired) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/servo_cmd_decoder.sv
// Framed servo command parser: SYNC, ID, VALUE, CHK -> per-channel value.
// Ports: clk, rst, rx_dv, rx_byte in; servo_value, servo_upd,
// frame_active, err_chk, err_id, err_timeout out (all registered).
module servo_cmd_decoder
  import servo_cmd_pkg::*;
#(
  parameter int         NUM_SERVOS    = 3,
  parameter logic [7:0] DEFAULT_VALUE = 8'd127,
  parameter int         TIMEOUT_CLKS  = 120000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_dv,
  input  logic [7:0]              rx_byte,
  output logic [8*NUM_SERVOS-1:0] servo_value,
  output logic [NUM_SERVOS-1:0]   servo_upd,
  output logic                    frame_active,
  output logic                    err_chk,
  output logic                    err_id,
  output logic                    err_timeout
);

  localparam logic [7:0] NUM_ID = 8'(NUM_SERVOS);

  state_e                  state_q;
  logic                    rx_dv_q;
  logic [7:0]              id_q;
  logic [7:0]              val_q;
  logic [8*NUM_SERVOS-1:0] value_q;
  logic [NUM_SERVOS-1:0]   upd_q;
  logic                    active_q;
  logic                    err_chk_q;
  logic                    err_id_q;
  logic                    err_to_q;
  logic                    accept;
  logic                    expired;

  // A long strobe is one byte: only the rising edge counts.
  assign accept = rx_dv && !rx_dv_q;

  servo_frame_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept || (state_q == S_SYNC)),
    .run    (state_q != S_SYNC),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_SYNC;
      rx_dv_q   <= 1'b0;
      id_q      <= '0;
      val_q     <= '0;
      value_q   <= {NUM_SERVOS{DEFAULT_VALUE}};
      upd_q     <= '0;
      active_q  <= 1'b0;
      err_chk_q <= 1'b0;
      err_id_q  <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      rx_dv_q   <= rx_dv;
      upd_q     <= '0;
      err_chk_q <= 1'b0;
      err_id_q  <= 1'b0;
      err_to_q  <= 1'b0;
      if (accept) begin
        unique case (state_q)
          S_SYNC: begin
            if (rx_byte == SYNC_BYTE) begin
              state_q  <= S_ID;
              active_q <= 1'b1;
            end
          end
          S_ID: begin
            id_q    <= rx_byte;
            state_q <= S_VALUE;
          end
          S_VALUE: begin
            val_q   <= rx_byte;
            state_q <= S_CHK;
          end
          S_CHK: begin
            state_q  <= S_SYNC;
            active_q <= 1'b0;
            // Checksum failure outranks a bad ID.
            if (rx_byte != frame_chk(id_q, val_q)) begin
              err_chk_q <= 1'b1;
            end else if (id_q >= NUM_ID) begin
              err_id_q <= 1'b1;
            end else begin
              for (int n = 0; n < NUM_SERVOS; n++) begin
                if (id_q == 8'(n)) begin
                  value_q[8*n +: 8] <= val_q;
                  upd_q[n]          <= 1'b1;
                end
              end
            end
          end
        endcase
      end else if (expired) begin
        state_q  <= S_SYNC;
        active_q <= 1'b0;
        err_to_q <= 1'b1;
      end
    end
  end

  assign servo_value  = value_q;
  assign servo_upd    = upd_q;
  assign frame_active = active_q;
  assign err_chk      = err_chk_q;
  assign err_id       = err_id_q;
  assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_servo_cmd_decoder.sv
// Self-checking bench for servo_cmd_decoder: table vectors,
// directed multi-cycle sequences and random frames vs. a byte-queue model.
module tb_servo_cmd_decoder;

  localparam int NS = 3;
  localparam int TO = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic [8*NS-1:0] servo_value;
  logic [NS-1:0] servo_upd;
  logic          frame_active;
  logic          err_chk;
  logic          err_id;
  logic          err_timeout;

  servo_cmd_decoder #(
    .NUM_SERVOS   (NS),
    .DEFAULT_VALUE(8'd127),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_dv       (rx_dv),
    .rx_byte     (rx_byte),
    .servo_value (servo_value),
    .servo_upd   (servo_upd),
    .frame_active(frame_active),
    .err_chk     (err_chk),
    .err_id      (err_id),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Pulse counters observed on the DUT outputs.
  int m_upd[NS];
  int m_chk = 0;
  int m_id = 0;
  int m_to = 0;

  // Reference model: pending frame bytes plus expected totals.
  logic [7:0] mq[$];
  logic [7:0] e_val[NS];
  int e_upd[NS];
  int e_chk = 0;
  int e_id = 0;
  int e_to = 0;

  always @(negedge clk) begin
    if (!rst) begin
      for (int n = 0; n < NS; n++)
        if (servo_upd[n]) m_upd[n]++;
      if (err_chk) m_chk++;
      if (err_id) m_id++;
      if (err_timeout) m_to++;
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (mq.size() == 0) begin
      if (b == 8'hA5) mq.push_back(b);
    end else begin
      mq.push_back(b);
      if (mq.size() == 4) begin
        if ((mq[0] ^ mq[1] ^ mq[2]) != mq[3]) e_chk++;
        else if (mq[1] >= 8'(NS)) e_id++;
        else begin
          e_val[mq[1]] = mq[2];
          e_upd[mq[1]]++;
        end
        mq.delete();
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int n = 0; n < NS; n++) e_val[n] = 8'h7F;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int hold, input int gap);
    @(negedge clk);
    rx_byte = b;
    rx_dv = 1'b1;
    repeat (hold) @(negedge clk);
    rx_dv = 1'b0;
    repeat (gap) @(negedge clk);
    model_byte(b);
  endtask

  task automatic send_frame(input logic [31:0] f, input int hold);
    for (int i = 3; i >= 0; i--) send_byte(f[8*i +: 8], hold, 1);
  endtask

  task automatic check_model(input string tag);
    for (int n = 0; n < NS; n++) begin
      check($sformatf("%s val%0d", tag, n),
            32'(servo_value[8*n +: 8]), 32'(e_val[n]));
      check($sformatf("%s upd%0d", tag, n), m_upd[n], e_upd[n]);
    end
    check({tag, " err_chk"}, m_chk, e_chk);
    check({tag, " err_id"}, m_id, e_id);
    check({tag, " err_to"}, m_to, e_to);
    check({tag, " active"}, 32'(frame_active), 32'(mq.size() != 0));
  endtask

  function automatic int upd_total();
    int s = 0;
    for (int n = 0; n < NS; n++) s += m_upd[n];
    return s;
  endfunction

  typedef struct {
    logic [31:0] frame;
    int          kind;   // 0 commit, 1 bad chk, 2 bad id
    int          ch;
    logic [7:0]  val;    // expected value of ch afterwards
  } vec_t;

  vec_t vt[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, c0, i0, t0, up0;
    logic [7:0] id, val, ck;

    for (int n = 0; n < NS; n++) begin
      m_upd[n] = 0;
      e_upd[n] = 0;
    end
    model_reset();

    vt[0] = '{32'hA50140E4, 0, 1, 8'h40};
    vt[1] = '{32'hA5028000, 1, 2, 8'h7F};
    vt[2] = '{32'hA50510B0, 2, 1, 8'h40};
    vt[3] = '{32'hA500A500, 0, 0, 8'hA5};
    vt[4] = '{32'hA5FF005A, 2, 0, 8'hA5};
    vt[5] = '{32'hA502C86F, 0, 2, 8'hC8};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset value", 32'(servo_value), 32'h7F7F7F);
    check("reset upd", 32'(servo_upd), 0);
    check("reset active", 32'(frame_active), 0);
    check("reset errs",
          32'({err_chk, err_id, err_timeout}), 0);

    for (int v = 0; v < 6; v++) begin
      u0 = m_upd[vt[v].ch];
      up0 = upd_total();
      c0 = m_chk;
      i0 = m_id;
      send_frame(vt[v].frame, 1);
      check($sformatf("vec%0d value", v),
            32'(servo_value[8*vt[v].ch +: 8]), 32'(vt[v].val));
      check($sformatf("vec%0d upd ch", v),
            m_upd[vt[v].ch] - u0, (vt[v].kind == 0) ? 1 : 0);
      check($sformatf("vec%0d upd all", v),
            upd_total() - up0, (vt[v].kind == 0) ? 1 : 0);
      check($sformatf("vec%0d chk", v),
            m_chk - c0, (vt[v].kind == 1) ? 1 : 0);
      check($sformatf("vec%0d id", v),
            m_id - i0, (vt[v].kind == 2) ? 1 : 0);
      check($sformatf("vec%0d active", v), 32'(frame_active), 0);
      check_model($sformatf("vec%0d", v));
    end

    // Resync through garbage.
    u0 = m_upd[2];
    c0 = m_chk + m_id + m_to;
    send_byte(8'h00, 1, 1);
    send_byte(8'h12, 1, 1);
    send_byte(8'hFF, 1, 1);
    send_frame(32'hA5023394, 1);
    check("resync ch2", 32'(servo_value[23:16]), 32'h33);
    check("resync upd2", m_upd[2] - u0, 1);
    check("resync errs", m_chk + m_id + m_to - c0, 0);
    check_model("resync");

    // Timeout: err_timeout is due exactly TO clocks after the ID byte.
    t0 = m_to;
    send_byte(8'hA5, 1, 1);
    send_byte(8'h00, 1, 1);
    check("to active", 32'(frame_active), 1);
    repeat (TO - 2) @(negedge clk);
    check("to early pulse", 32'(err_timeout), 0);
    check("to early active", 32'(frame_active), 1);
    @(negedge clk);
    check("to pulse", 32'(err_timeout), 1);
    check("to active fall", 32'(frame_active), 0);
    e_to++;
    mq.delete();
    repeat (TO + 20) @(negedge clk);
    check("to once", m_to - t0, 1);
    send_frame(32'hA500C86D, 1);
    check("to after ch0", 32'(servo_value[7:0]), 32'hC8);
    check_model("timeout");

    // Reset mid-frame discards the partial frame.
    send_byte(8'hA5, 1, 1);
    send_byte(8'h01, 1, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    up0 = upd_total();
    send_byte(8'h40, 1, 1);
    send_byte(8'hE4, 1, 1);
    check("rst ch1", 32'(servo_value[15:8]), 32'h7F);
    check("rst no upd", upd_total() - up0, 0);
    check_model("rst");

    // Long strobe: 3-clock rx_dv per byte counts once.
    u0 = m_upd[0];
    send_frame(32'hA50011B4, 3);
    check("strobe ch0", 32'(servo_value[7:0]), 32'h11);
    check("strobe upd0", m_upd[0] - u0, 1);
    check_model("strobe");

    // Random frames, stray bytes and corrupted checksums.
    for (int r = 0; r < 60; r++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        send_byte(8'($urandom), int'($urandom_range(1, 3)),
                  int'($urandom_range(1, 3)));
      end else begin
        id = 8'($urandom_range(0, 3));
        val = 8'($urandom);
        ck = 8'hA5 ^ id ^ val;
        if (kind == 3) ck = ck ^ (8'd1 << $urandom_range(0, 7));
        send_byte(8'hA5, int'($urandom_range(1, 3)), 1);
        send_byte(id, int'($urandom_range(1, 3)),
                  int'($urandom_range(1, 3)));
        send_byte(val, int'($urandom_range(1, 3)), 1);
        send_byte(ck, int'($urandom_range(1, 3)),
                  int'($urandom_range(1, 3)));
      end
      check_model($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
